// File: rtl/wf_fetch_unit.sv
// rtl/wf_fetch_unit.sv - wavefront slot allocation, round-robin instruction fetch, branch redirect and completion.
// Optional FETCH_ACK_GATE_EN: limit to one outstanding fetch request until buff_ack.
module wf_fetch_unit #(
    parameter int NUM_WF      = 40,
    parameter int FETCH_BYTES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dispatch2cu_wf_dispatch,
    input  logic [14:0]        dispatch2cu_wf_tag_dispatch,
    input  logic [31:0]        dispatch2cu_start_pc_dispatch,
    input  logic [9:0]         dispatch2cu_vgpr_base_dispatch,
    input  logic [8:0]         dispatch2cu_sgpr_base_dispatch,
    input  logic [15:0]        dispatch2cu_lds_base_dispatch,
    input  logic [5:0]         dispatch2cu_wf_size_dispatch,
    input  logic [3:0]         dispatch2cu_wg_wf_count,
    input  logic               buff_ack,
    input  logic [NUM_WF-1:0]  wave_stop_fetch,
    input  logic               issue_wf_done_en,
    input  logic [5:0]         issue_wf_done_wf_id,
    input  logic [5:0]         issue_wg_wfid,
    input  logic               salu_branch_en,
    input  logic [5:0]         salu_branch_wfid,
    input  logic               salu_branch_taken,
    input  logic [31:0]        salu_branch_pc_value,
    output logic               cu2dispatch_wf_done,
    output logic [14:0]        cu2dispatch_wf_tag_done,
    output logic               buff_rd_en,
    output logic [31:0]        buff_addr,
    output logic [38:0]        buff_tag,
    output logic               wave_reserve_valid,
    output logic [5:0]         wave_reserve_slotid,
    output logic               wave_basereg_wr,
    output logic [5:0]         wave_basereg_wfid,
    output logic [9:0]         wave_vgpr_base,
    output logic [8:0]         wave_sgpr_base,
    output logic [15:0]        wave_lds_base,
    output logic               exec_init_wf_en,
    output logic [5:0]         exec_init_wf_id,
    output logic [63:0]        exec_init_value,
    output logic [5:0]         issue_wg_wgid,
    output logic [3:0]         issue_wg_wf_count
);

    logic [NUM_WF-1:0] slot_valid;
    logic [NUM_WF-1:0] slot_first;
    logic [31:0]       slot_pc  [NUM_WF];
    logic [14:0]       slot_tag [NUM_WF];
    logic [3:0]        slot_cnt [NUM_WF];

    logic [5:0]        rr_ptr;
    logic [5:0]        new_vacant;
    logic              has_vacant;
    logic              alloc;
    logic [NUM_WF-1:0] eligible;
    logic [6:0]        rr_sum;
    logic [5:0]        rr_idx;
    logic              gnt_found;
    logic [5:0]        gnt_id;
    logic              can_grant;
    logic              grant;
    logic              done_hit;

    // Vacancy is judged on registered state, so a slot freed this cycle stays taken.
    always_comb begin
        new_vacant = '0;
        has_vacant = 1'b0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                new_vacant = 6'(i);
                has_vacant = 1'b1;
            end
        end
    end

    assign alloc = dispatch2cu_wf_dispatch && has_vacant;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            eligible[i] = slot_valid[i] && !wave_stop_fetch[i] && !(alloc && new_vacant == 6'(i));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            rr_sum = {1'b0, rr_ptr} + 7'(k);
            rr_idx = (rr_sum >= 7'(NUM_WF)) ? 6'(rr_sum - 7'(NUM_WF)) : rr_sum[5:0];
            if (!gnt_found && eligible[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = rr_idx;
            end
        end
    end

`ifdef FETCH_ACK_GATE_EN
    logic outstanding;

    assign can_grant = !outstanding || buff_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else if (grant) begin
            outstanding <= 1'b1;
        end else if (buff_ack) begin
            outstanding <= 1'b0;
        end
    end
`else
    logic unused_buff_ack;

    assign can_grant       = 1'b1;
    assign unused_buff_ack = buff_ack;
`endif

    assign grant    = gnt_found && can_grant;
    assign done_hit = issue_wf_done_en && (issue_wf_done_wf_id < 6'(NUM_WF));

    assign issue_wg_wgid     = (issue_wg_wfid < 6'(NUM_WF)) ? slot_tag[issue_wg_wfid][5:0] : '0;
    assign issue_wg_wf_count = (issue_wg_wfid < 6'(NUM_WF)) ? slot_cnt[issue_wg_wfid] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            slot_first <= '0;
            for (int i = 0; i < NUM_WF; i++) begin
                slot_pc[i]  <= '0;
                slot_tag[i] <= '0;
                slot_cnt[i] <= '0;
            end
            rr_ptr                  <= '0;
            buff_rd_en              <= 1'b0;
            buff_addr               <= '0;
            buff_tag                <= '0;
            wave_reserve_valid      <= 1'b0;
            wave_reserve_slotid     <= '0;
            wave_basereg_wr         <= 1'b0;
            wave_basereg_wfid       <= '0;
            wave_vgpr_base          <= '0;
            wave_sgpr_base          <= '0;
            wave_lds_base           <= '0;
            exec_init_wf_en         <= 1'b0;
            exec_init_wf_id         <= '0;
            exec_init_value         <= '0;
            cu2dispatch_wf_done     <= 1'b0;
            cu2dispatch_wf_tag_done <= '0;
        end else begin
            // Per-slot priority: allocate, then done, then taken branch, then fetch increment.
            for (int i = 0; i < NUM_WF; i++) begin
                if (alloc && new_vacant == 6'(i)) begin
                    slot_valid[i] <= 1'b1;
                    slot_first[i] <= 1'b1;
                    slot_pc[i]    <= dispatch2cu_start_pc_dispatch;
                    slot_tag[i]   <= dispatch2cu_wf_tag_dispatch;
                    slot_cnt[i]   <= dispatch2cu_wg_wf_count;
                end else if (issue_wf_done_en && issue_wf_done_wf_id == 6'(i)) begin
                    slot_valid[i] <= 1'b0;
                end else if (salu_branch_en && salu_branch_taken && slot_valid[i]
                             && salu_branch_wfid == 6'(i)) begin
                    slot_pc[i]    <= salu_branch_pc_value;
                    slot_first[i] <= 1'b1;
                end else if (grant && gnt_id == 6'(i)) begin
                    slot_pc[i]    <= slot_pc[i] + 32'(FETCH_BYTES);
                    slot_first[i] <= 1'b0;
                end
            end

            buff_rd_en <= grant;
            if (grant) begin
                rr_ptr    <= (gnt_id == 6'(NUM_WF - 1)) ? '0 : gnt_id + 6'd1;
                buff_addr <= slot_pc[gnt_id];
                buff_tag  <= {slot_pc[gnt_id], gnt_id, slot_first[gnt_id]};
            end

            wave_reserve_valid <= alloc;
            wave_basereg_wr    <= alloc;
            exec_init_wf_en    <= alloc;
            if (alloc) begin
                wave_reserve_slotid <= new_vacant;
                wave_basereg_wfid   <= new_vacant;
                exec_init_wf_id     <= new_vacant;
                wave_vgpr_base      <= dispatch2cu_vgpr_base_dispatch;
                wave_sgpr_base      <= dispatch2cu_sgpr_base_dispatch;
                wave_lds_base       <= dispatch2cu_lds_base_dispatch;
                exec_init_value     <= {64{1'b1}} >> (6'd63 - dispatch2cu_wf_size_dispatch);
            end

            cu2dispatch_wf_done <= done_hit;
            if (done_hit) begin
                cu2dispatch_wf_tag_done <= slot_tag[issue_wf_done_wf_id];
            end
        end
    end

endmodule

// File: tb/tb_wf_fetch_unit.sv
// tb/tb_wf_fetch_unit.sv - scoreboard bench for wf_fetch_unit with directed dispatch, fetch, branch and done vectors.
module tb_wf_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch2cu_wf_dispatch;
    logic [14:0] dispatch2cu_wf_tag_dispatch;
    logic [31:0] dispatch2cu_start_pc_dispatch;
    logic [9:0]  dispatch2cu_vgpr_base_dispatch;
    logic [8:0]  dispatch2cu_sgpr_base_dispatch;
    logic [15:0] dispatch2cu_lds_base_dispatch;
    logic [5:0]  dispatch2cu_wf_size_dispatch;
    logic [3:0]  dispatch2cu_wg_wf_count;
    logic        buff_ack;
    logic [39:0] wave_stop_fetch;
    logic        issue_wf_done_en;
    logic [5:0]  issue_wf_done_wf_id;
    logic [5:0]  issue_wg_wfid;
    logic        salu_branch_en;
    logic [5:0]  salu_branch_wfid;
    logic        salu_branch_taken;
    logic [31:0] salu_branch_pc_value;
    logic        cu2dispatch_wf_done;
    logic [14:0] cu2dispatch_wf_tag_done;
    logic        buff_rd_en;
    logic [31:0] buff_addr;
    logic [38:0] buff_tag;
    logic        wave_reserve_valid;
    logic [5:0]  wave_reserve_slotid;
    logic        wave_basereg_wr;
    logic [5:0]  wave_basereg_wfid;
    logic [9:0]  wave_vgpr_base;
    logic [8:0]  wave_sgpr_base;
    logic [15:0] wave_lds_base;
    logic        exec_init_wf_en;
    logic [5:0]  exec_init_wf_id;
    logic [63:0] exec_init_value;
    logic [5:0]  issue_wg_wgid;
    logic [3:0]  issue_wg_wf_count;

    always #5 clk = ~clk;

    wf_fetch_unit dut (
        .clk                            (clk),
        .rst                            (rst),
        .dispatch2cu_wf_dispatch        (dispatch2cu_wf_dispatch),
        .dispatch2cu_wf_tag_dispatch    (dispatch2cu_wf_tag_dispatch),
        .dispatch2cu_start_pc_dispatch  (dispatch2cu_start_pc_dispatch),
        .dispatch2cu_vgpr_base_dispatch (dispatch2cu_vgpr_base_dispatch),
        .dispatch2cu_sgpr_base_dispatch (dispatch2cu_sgpr_base_dispatch),
        .dispatch2cu_lds_base_dispatch  (dispatch2cu_lds_base_dispatch),
        .dispatch2cu_wf_size_dispatch   (dispatch2cu_wf_size_dispatch),
        .dispatch2cu_wg_wf_count        (dispatch2cu_wg_wf_count),
        .buff_ack                       (buff_ack),
        .wave_stop_fetch                (wave_stop_fetch),
        .issue_wf_done_en               (issue_wf_done_en),
        .issue_wf_done_wf_id            (issue_wf_done_wf_id),
        .issue_wg_wfid                  (issue_wg_wfid),
        .salu_branch_en                 (salu_branch_en),
        .salu_branch_wfid               (salu_branch_wfid),
        .salu_branch_taken              (salu_branch_taken),
        .salu_branch_pc_value           (salu_branch_pc_value),
        .cu2dispatch_wf_done            (cu2dispatch_wf_done),
        .cu2dispatch_wf_tag_done        (cu2dispatch_wf_tag_done),
        .buff_rd_en                     (buff_rd_en),
        .buff_addr                      (buff_addr),
        .buff_tag                       (buff_tag),
        .wave_reserve_valid             (wave_reserve_valid),
        .wave_reserve_slotid            (wave_reserve_slotid),
        .wave_basereg_wr                (wave_basereg_wr),
        .wave_basereg_wfid              (wave_basereg_wfid),
        .wave_vgpr_base                 (wave_vgpr_base),
        .wave_sgpr_base                 (wave_sgpr_base),
        .wave_lds_base                  (wave_lds_base),
        .exec_init_wf_en                (exec_init_wf_en),
        .exec_init_wf_id                (exec_init_wf_id),
        .exec_init_value                (exec_init_value),
        .issue_wg_wgid                  (issue_wg_wgid),
        .issue_wg_wf_count              (issue_wg_wf_count)
    );

    typedef struct {
        logic [5:0]  slot;
        logic [9:0]  vgpr;
        logic [8:0]  sgpr;
        logic [15:0] lds;
        logic [63:0] exec;
    } disp_t;

    disp_t       disp_q [$];
    logic [38:0] fetch_q[$];
    logic [14:0] done_q [$];
    disp_t       mon_d;
    logic [38:0] mon_f;
    logic [14:0] mon_t;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [14:0] tag, input logic [31:0] pc, input logic [9:0] vgpr,
                            input logic [8:0] sgpr, input logic [15:0] lds, input logic [5:0] size,
                            input logic [3:0] cnt, input logic expect_alloc, input logic [5:0] slot,
                            input logic [63:0] exec);
        disp_t d;
        dispatch2cu_wf_dispatch        = 1'b1;
        dispatch2cu_wf_tag_dispatch    = tag;
        dispatch2cu_start_pc_dispatch  = pc;
        dispatch2cu_vgpr_base_dispatch = vgpr;
        dispatch2cu_sgpr_base_dispatch = sgpr;
        dispatch2cu_lds_base_dispatch  = lds;
        dispatch2cu_wf_size_dispatch   = size;
        dispatch2cu_wg_wf_count        = cnt;
        if (expect_alloc) begin
            d.slot = slot; d.vgpr = vgpr; d.sgpr = sgpr; d.lds = lds; d.exec = exec;
            disp_q.push_back(d);
        end
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
    endtask

    task automatic exp_fetch(input logic [31:0] pc, input logic [5:0] slot, input logic ff);
        fetch_q.push_back({pc, slot, ff});
    endtask

    task automatic check_all_zero(input string name);
        check(name, {63'b0, |{cu2dispatch_wf_done, cu2dispatch_wf_tag_done, buff_rd_en, buff_addr,
                               buff_tag, wave_reserve_valid, wave_reserve_slotid, wave_basereg_wr,
                               wave_basereg_wfid, wave_vgpr_base, wave_sgpr_base, wave_lds_base,
                               exec_init_wf_en, exec_init_wf_id, exec_init_value,
                               issue_wg_wgid, issue_wg_wf_count}}, 64'd0);
    endtask

    task automatic check_wg(input logic [5:0] wfid, input logic [5:0] wgid, input logic [3:0] cnt);
        issue_wg_wfid = wfid;
        #1;
        check("wg_wgid", issue_wg_wgid, wgid);
        check("wg_wf_count", issue_wg_wf_count, cnt);
    endtask

    always @(negedge clk) begin
        if (wave_basereg_wr || wave_reserve_valid || exec_init_wf_en) begin
            if (disp_q.size() == 0) begin
                check("disp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_d = disp_q.pop_front();
                check("disp_pulses", {wave_reserve_valid, wave_basereg_wr, exec_init_wf_en}, 64'h7);
                check("reserve_slotid", wave_reserve_slotid, mon_d.slot);
                check("basereg_wfid", wave_basereg_wfid, mon_d.slot);
                check("exec_init_wf_id", exec_init_wf_id, mon_d.slot);
                check("vgpr_base", wave_vgpr_base, mon_d.vgpr);
                check("sgpr_base", wave_sgpr_base, mon_d.sgpr);
                check("lds_base", wave_lds_base, mon_d.lds);
                check("exec_init_value", exec_init_value, mon_d.exec);
            end
        end
        if (buff_rd_en) begin
            if (fetch_q.size() == 0) begin
                check("fetch_unexpected", {32'd0, buff_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_f = fetch_q.pop_front();
                check("buff_addr", buff_addr, mon_f[38:7]);
                check("buff_tag", buff_tag, mon_f);
            end
        end
        if (cu2dispatch_wf_done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", {49'd0, cu2dispatch_wf_tag_done}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_t = done_q.pop_front();
                check("done_tag", cu2dispatch_wf_tag_done, mon_t);
            end
        end
    end

    initial begin
        rst = 1'b1;
        dispatch2cu_wf_dispatch = 1'b0;
        dispatch2cu_wf_tag_dispatch = '0;
        dispatch2cu_start_pc_dispatch = '0;
        dispatch2cu_vgpr_base_dispatch = '0;
        dispatch2cu_sgpr_base_dispatch = '0;
        dispatch2cu_lds_base_dispatch = '0;
        dispatch2cu_wf_size_dispatch = '0;
        dispatch2cu_wg_wf_count = '0;
        buff_ack = 1'b1;
        wave_stop_fetch = '1;
        issue_wf_done_en = 1'b0;
        issue_wf_done_wf_id = '0;
        issue_wg_wfid = '0;
        salu_branch_en = 1'b0;
        salu_branch_wfid = '0;
        salu_branch_taken = 1'b0;
        salu_branch_pc_value = '0;

        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset_outputs");

        dispatch(15'd0, 32'd0, 10'd0, 9'd0, 16'd0, 6'd0, 4'd3, 1'b1, 6'd0, 64'h1);
        dispatch(15'd5, 32'd18, 10'd9, 9'd10, 16'd20, 6'd6, 4'd7, 1'b1, 6'd1, 64'h7F);
        check_wg(6'd1, 6'd5, 4'd7);
        check_wg(6'd0, 6'd0, 4'd3);

        // Two slots alternate: 0,18 then 32,50.
        exp_fetch(32'd0, 6'd0, 1'b1);
        exp_fetch(32'd18, 6'd1, 1'b1);
        exp_fetch(32'd32, 6'd0, 1'b0);
        exp_fetch(32'd50, 6'd1, 1'b0);
        wave_stop_fetch = ~40'h3;
        repeat (4) tick();
        wave_stop_fetch = '1;

        // Branch disabled, then enabled-but-not-taken: slot 0 keeps pc 64.
        salu_branch_en = 1'b0; salu_branch_taken = 1'b1; salu_branch_wfid = 6'd0;
        salu_branch_pc_value = 32'h20;
        tick();
        salu_branch_en = 1'b1; salu_branch_taken = 1'b0; salu_branch_pc_value = 32'h24;
        tick();
        salu_branch_en = 1'b0;
        exp_fetch(32'd64, 6'd0, 1'b0);
        wave_stop_fetch = ~40'h1;
        tick();
        wave_stop_fetch = '1;

        salu_branch_en = 1'b1; salu_branch_taken = 1'b1; salu_branch_pc_value = 32'h30;
        tick();
        salu_branch_en = 1'b0;
        exp_fetch(32'h30, 6'd0, 1'b1);
        wave_stop_fetch = ~40'h1;
        tick();
        wave_stop_fetch = '1;

        // Branch in the same cycle as a grant on that slot overrides the increment.
        exp_fetch(32'h50, 6'd0, 1'b0);
        exp_fetch(32'h100, 6'd0, 1'b1);
        wave_stop_fetch = ~40'h1;
        salu_branch_en = 1'b1; salu_branch_taken = 1'b1; salu_branch_pc_value = 32'h100;
        tick();
        salu_branch_en = 1'b0;
        tick();
        wave_stop_fetch = '1;

        // Done on slot 0 with a same-cycle dispatch: new wave lands in slot 2.
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd0;
        done_q.push_back(15'd0);
        dispatch(15'd9, 32'h200, 10'd1, 9'd2, 16'd3, 6'd1, 4'd2, 1'b1, 6'd2, 64'h3);
        issue_wf_done_en = 1'b0;
        wave_stop_fetch = ~40'h1;
        repeat (2) tick();
        wave_stop_fetch = '1;
        dispatch(15'd12, 32'h300, 10'd4, 9'd5, 16'd6, 6'd3, 4'd4, 1'b1, 6'd0, 64'hF);
        check_wg(6'd0, 6'd12, 4'd4);
        check_wg(6'd2, 6'd9, 4'd2);

        // Slot 1 inhibited: only 2 and 0 alternate.
        exp_fetch(32'h200, 6'd2, 1'b1);
        exp_fetch(32'h300, 6'd0, 1'b1);
        exp_fetch(32'h220, 6'd2, 1'b0);
        exp_fetch(32'h320, 6'd0, 1'b0);
        wave_stop_fetch = ~40'h5;
        repeat (4) tick();
        wave_stop_fetch = '1;
        tick();

        buff_ack = 1'b0;
`ifdef FETCH_ACK_GATE_EN
        exp_fetch(32'h240, 6'd2, 1'b0);
`else
        exp_fetch(32'h240, 6'd2, 1'b0);
        exp_fetch(32'h260, 6'd2, 1'b0);
        exp_fetch(32'h280, 6'd2, 1'b0);
`endif
        wave_stop_fetch = ~40'h4;
        repeat (3) tick();
        wave_stop_fetch = '1;
        buff_ack = 1'b1;
        tick();

        // Reset with a done in flight: no completion pulse.
        rst = 1'b1;
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd2;
        tick();
        issue_wf_done_en = 1'b0;
        tick();
        rst = 1'b0;
        check_all_zero("midrun_reset_outputs");
        check_wg(6'd2, 6'd0, 4'd0);

        for (int i = 0; i < 40; i++) begin
            dispatch(15'(64 + i), 32'(i * 256), 10'(i), 9'(i), 16'(i), 6'd0, 4'(i % 16), 1'b1, 6'(i), 64'h1);
        end
        dispatch(15'd99, 32'h0, 10'd1, 9'd1, 16'd1, 6'd5, 4'd1, 1'b0, 6'd0, 64'h0);
        check_wg(6'd39, 6'd39, 4'd7);
        check_wg(6'd0, 6'd0, 4'd0);
        repeat (3) tick();

        check("disp_q_empty", disp_q.size(), 64'd0);
        check("fetch_q_empty", fetch_q.size(), 64'd0);
        check("done_q_empty", done_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wf_fetch_unit.md
Name: wf_fetch_unit

Overview:
- Instruction-fetch front end of a compute unit.
- Accepts wavefront dispatches and allocates one of 40 wavefront slots, holding per-slot PC, dispatch tag and workgroup info.
- Issues round-robin fetch requests to the instruction buffer, applies scalar-ALU branch redirects, and reports wavefront completion back to the dispatcher.

Parameters:
- NUM_WF, 40, number of wavefront slots; slot id is 6 bits.
- FETCH_BYTES, 32, PC advance per fetch request.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dispatch2cu_wf_dispatch  in  1  new-wavefront strobe.
- dispatch2cu_wf_tag_dispatch  in  15  dispatcher tag.
- dispatch2cu_start_pc_dispatch  in  32  start PC.
- dispatch2cu_vgpr_base_dispatch  in  10  VGPR base.
- dispatch2cu_sgpr_base_dispatch  in  9  SGPR base.
- dispatch2cu_lds_base_dispatch  in  16  LDS base.
- dispatch2cu_wf_size_dispatch  in  6  active lanes minus 1.
- dispatch2cu_wg_wf_count  in  4  wavefronts in the workgroup.
- buff_ack  in  1  instruction buffer accepted the outstanding request.
- wave_stop_fetch  in  40  per-slot fetch inhibit.
- issue_wf_done_en  in  1  wavefront finished.
- issue_wf_done_wf_id  in  6  slot of the finished wavefront.
- issue_wg_wfid  in  6  slot to look up for workgroup info.
- salu_branch_en  in  1  branch resolved.
- salu_branch_wfid  in  6  branch slot.
- salu_branch_taken  in  1  branch taken.
- salu_branch_pc_value  in  32  branch target.
- cu2dispatch_wf_done  out  1  completion pulse.
- cu2dispatch_wf_tag_done  out  15  tag of the completed wavefront.
- buff_rd_en  out  1  fetch request strobe.
- buff_addr  out  32  fetch PC.
- buff_tag  out  39  {pc[31:0], wfid[5:0], first_fetch}.
- wave_reserve_valid  out  1  slot reserved.
- wave_reserve_slotid  out  6  reserved slot.
- wave_basereg_wr  out  1  base-register write strobe.
- wave_basereg_wfid  out  6  base-register slot.
- wave_vgpr_base  out  10  VGPR base.
- wave_sgpr_base  out  9  SGPR base.
- wave_lds_base  out  16  LDS base.
- exec_init_wf_en  out  1  EXEC init strobe.
- exec_init_wf_id  out  6  EXEC init slot.
- exec_init_value  out  64  initial EXEC mask.
- issue_wg_wgid  out  6  workgroup id of slot issue_wg_wfid.
- issue_wg_wf_count  out  4  workgroup wavefront count of slot issue_wg_wfid.

Behaviour:
- Reset: every output 0; all slots vacant; round-robin pointer 0; no outstanding request.
- Slot state per slot: valid, pc, tag, wgid (= tag[5:0]), wf_count, first_fetch.
- Allocation: new_vacant = lowest-index vacant slot. On dispatch the slot is written at the edge, valid=1 and first_fetch=1.
- Dispatch outputs, registered, pulse exactly 1 cycle after the dispatch cycle:
  - wave_reserve_valid, wave_basereg_wr and exec_init_wf_en pulse.
  - slotid, wfid and exec_init_wf_id all equal the allocated slot.
  - Base values are the dispatched values.
  - exec_init_value bits [wf_size:0] = 1, rest 0.
- Dispatch with no vacant slot: ignored, no outputs.
- Workgroup lookup: issue_wg_wgid and issue_wg_wf_count are combinational from slot issue_wg_wfid. Vacant slot yields the last stored values.
- Fetch arbitration:
  - Eligible = valid AND !wave_stop_fetch[i] AND not allocated this cycle.
  - Round-robin from the pointer; after a grant the pointer moves to granted slot + 1 (wraps 39 -> 0).
  - Grant drives a one-cycle buff_rd_en with buff_addr = slot pc and buff_tag = {pc, slot, first_fetch}.
  - On grant: pc += 32 (32-bit wrap) and first_fetch cleared.
  - buff_addr and buff_tag hold their values while idle.
- Outstanding: after a grant no new grant until buff_ack is seen (ack-cycle grant allowed). Gating per the optional feature.
- Branch: salu_branch_en && taken sets pc[wfid] = target and first_fetch=1. Not taken: no change.
  - Branch beats increment on the same slot in the same cycle.
  - A branch to a vacant slot is ignored.
- Done: on issue_wf_done_en the slot is vacated at the edge. The next cycle pulses cu2dispatch_wf_done with the stored tag.
  - A slot freed this cycle is not reusable by a same-cycle dispatch.
- Done and branch to the same slot in one cycle: done wins.
- rst mid-operation: returns to reset state on the next edge; the pending done pulse is dropped.

Optional Feature:
- FETCH_ACK_GATE_EN defined: one outstanding request; grants blocked until buff_ack as above.
- Not defined: buff_ack is ignored; a grant is allowed every cycle.

Test Plan:
- Reset 2 cycles -> all outputs 0; a dispatch (tag 0, pc 0, count 3, size 0) -> next cycle basereg_wr=1, wfid=0, exec_init_value=64'h1, reserve_slotid=0.
- Second dispatch (tag 5, pc 18, vgpr 9, sgpr 10, lds 20, size 6, count 7) -> wfid=1, bases 9/10/20, exec_init_value=64'h7F; issue_wg_wfid=1 -> wgid=5, wf_count=7.
- Macro undefined, both slots valid -> buff_rd_en alternates slots 0,1; addresses 0,18 then 32,50; first grant tag bit0=1.
- Branch en=0 with taken=1 (target 0x20) -> no change; en=1, taken, wfid 0, 0x30 -> next slot-0 fetch at 0x30.
- done for slot 0 -> next cycle cu2dispatch_wf_done=1, tag 0; slot 0 stops fetching; the next dispatch reuses slot 0.
- wave_stop_fetch[1]=1 -> slot 1 is never granted; macro defined with no buff_ack -> exactly one grant.
